next_pc_unit: RTL and testbench

Parametrised next-PC generator for the in-order RISC-V core. It sits in front of the IF stage. Each cycle it selects the next fetch address from four sources: trap vector, `mepc` on MRET, branch/jump target, or sequential increment. It owns the architectural fetch PC register. When a redirect arrives while instruction fetch is stalled, it latches the redirect target in a pending-redirect FSM and replays it once fetch frees, so a single-cycle redirect is never lost.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/pc_redirect_hold.sv | 67 ++++++
 rtl/next_pc_unit.sv | 89 ++++++++
 tb/tb_next_pc_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the fetch front end: redirect sources, next-PC FSM states
// and the debug view of the pending-redirect FSM.
package cpu_pkg;

   typedef enum logic [1:0] {NONE, TRAP, MRET, BRANCH} redir_src_e;

   typedef enum logic {IDLE, HOLD} pcfsm_e;

   typedef struct packed {
      pcfsm_e     state;
      redir_src_e src;
   } pc_dbg_t;

endpackage

// File: rtl/pc_redirect_hold.sv
// Pending-redirect FSM: captures a redirect that arrives while fetch is stalled
// and supplies its target for replay once fetch frees.
module pc_redirect_hold
   import cpu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fetch_wait,
   input  redir_src_e       redir_src,
   input  logic [XLEN-1:0]  redir_tgt,
   output pcfsm_e           state,
   output redir_src_e       held_src,
   output logic [XLEN-1:0]  replay_tgt
);

   pcfsm_e            state_nxt;
   redir_src_e        held_src_nxt;
   logic [XLEN-1:0]   held_tgt;
   logic [XLEN-1:0]   held_tgt_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         held_tgt <= '0;
         held_src <= NONE;
      end else begin
         state    <= state_nxt;
         held_tgt <= held_tgt_nxt;
         held_src <= held_src_nxt;
      end
   end

   // The top arbitrates with trap first, so redir_src == TRAP carries trap_vec.
   always_comb begin
      state_nxt    = state;
      held_tgt_nxt = held_tgt;
      held_src_nxt = held_src;
      case (state)
         IDLE: begin
            if (redir_src != NONE && fetch_wait) begin
               state_nxt    = HOLD;
               held_tgt_nxt = redir_tgt;
               held_src_nxt = redir_src;
            end
         end
         HOLD: begin
            if (redir_src == TRAP) begin
               held_tgt_nxt = redir_tgt;
               held_src_nxt = TRAP;
            end
            if (!fetch_wait) begin
               state_nxt    = IDLE;
               held_src_nxt = NONE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      replay_tgt = held_tgt;
      if (state == HOLD && redir_src == TRAP) replay_tgt = redir_tgt;
   end

endmodule

// File: rtl/next_pc_unit.sv
// Next-PC generator: target arithmetic, redirect arbitration and the fetch PC
// register, with stalled redirects parked in pc_redirect_hold.
module next_pc_unit
   import cpu_pkg::*;
#(
   parameter int              XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter int              INST_BYTES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fetch_wait,
   input  logic             mem_wait,
   input  logic             wfi,
   input  logic             trap_take,
   input  logic [XLEN-1:0]  trap_vec,
   input  logic             mret,
   input  logic [XLEN-1:0]  mepc,
   input  logic             br_flush,
   input  logic             jalr,
   input  logic [XLEN-1:0]  ex_pc,
   input  logic [XLEN-1:0]  imm,
   input  logic [XLEN-1:0]  rs1_data,
   output logic [XLEN-1:0]  pc,
   output logic [XLEN-1:0]  next_pc,
   output logic [XLEN-1:0]  br_target,
   output logic [XLEN-1:0]  pc_plus,
   output logic             redirect_pending,
   output logic             target_misaligned,
   output pc_dbg_t          dbg
);

   logic [XLEN-1:0] tgt_sum;
   redir_src_e      win_src;
   logic [XLEN-1:0] win_tgt;
   pcfsm_e          fsm_state;
   redir_src_e      held_src;
   logic [XLEN-1:0] replay_tgt;

   assign tgt_sum   = (jalr ? rs1_data : ex_pc) + imm;
   assign br_target = {tgt_sum[XLEN-1:1], tgt_sum[0] & ~jalr};
   assign pc_plus   = pc + XLEN'(INST_BYTES);

   // With 16-bit instructions every even address is a legal target.
   assign target_misaligned = (INST_BYTES == 4) ? br_target[1] : 1'b0;

   always_comb begin
      win_src = NONE;
      win_tgt = br_target;
      if (trap_take) begin
         win_src = TRAP;
         win_tgt = trap_vec;
      end else if (mret) begin
         win_src = MRET;
         win_tgt = mepc;
      end else if (br_flush) begin
         win_src = BRANCH;
         win_tgt = br_target;
      end
   end

   pc_redirect_hold #(.XLEN(XLEN)) u_hold (
      .clk        (clk),
      .rst        (rst),
      .fetch_wait (fetch_wait),
      .redir_src  (win_src),
      .redir_tgt  (win_tgt),
      .state      (fsm_state),
      .held_src   (held_src),
      .replay_tgt (replay_tgt)
   );

   always_comb begin
      next_pc = pc_plus;
      if (fsm_state == HOLD)      next_pc = fetch_wait ? pc : replay_tgt;
      else if (win_src != NONE)   next_pc = win_tgt;
      else if (fetch_wait || mem_wait || wfi) next_pc = pc;
   end

   always_ff @(posedge clk) begin
      if (rst) pc <= RESET_PC;
      else     pc <= next_pc;
   end

   assign redirect_pending = (fsm_state == HOLD);
   assign dbg.state        = fsm_state;
   assign dbg.src          = held_src;

endmodule

// File: tb/tb_next_pc_unit.sv
// Bench for next_pc_unit: two instances (4-byte and 2-byte increment) share
// stimulus and are checked every cycle against a behavioural model.
module tb_next_pc_unit;
   import cpu_pkg::*;

   localparam logic [31:0] RST_PC = 32'h100;

   logic        clk = 1'b0;
   logic        rst, fetch_wait, mem_wait, wfi, trap_take, mret, br_flush, jalr;
   logic [31:0] trap_vec, mepc, ex_pc, imm, rs1_data;

   logic [31:0] pc4, npc4, bt4, pp4;
   logic        pend4, mis4;
   pc_dbg_t     dbg4;
   logic [31:0] pc2, npc2, bt2, pp2;
   logic        pend2, mis2;
   pc_dbg_t     dbg2;

   int total = 0;
   int bad   = 0;

   logic [31:0] m_pc [2];
   bit          m_pend;
   logic [31:0] m_held;
   redir_src_e  m_src;

   always #5 clk = ~clk;

   next_pc_unit #(.XLEN(32), .RESET_PC(RST_PC), .INST_BYTES(4)) u4 (
      .clk(clk), .rst(rst), .fetch_wait(fetch_wait), .mem_wait(mem_wait), .wfi(wfi),
      .trap_take(trap_take), .trap_vec(trap_vec), .mret(mret), .mepc(mepc),
      .br_flush(br_flush), .jalr(jalr), .ex_pc(ex_pc), .imm(imm), .rs1_data(rs1_data),
      .pc(pc4), .next_pc(npc4), .br_target(bt4), .pc_plus(pp4),
      .redirect_pending(pend4), .target_misaligned(mis4), .dbg(dbg4)
   );

   next_pc_unit #(.XLEN(32), .RESET_PC(RST_PC), .INST_BYTES(2)) u2 (
      .clk(clk), .rst(rst), .fetch_wait(fetch_wait), .mem_wait(mem_wait), .wfi(wfi),
      .trap_take(trap_take), .trap_vec(trap_vec), .mret(mret), .mepc(mepc),
      .br_flush(br_flush), .jalr(jalr), .ex_pc(ex_pc), .imm(imm), .rs1_data(rs1_data),
      .pc(pc2), .next_pc(npc2), .br_target(bt2), .pc_plus(pp2),
      .redirect_pending(pend2), .target_misaligned(mis2), .dbg(dbg2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      rst = 0; fetch_wait = 0; mem_wait = 0; wfi = 0;
      trap_take = 0; mret = 0; br_flush = 0; jalr = 0;
      trap_vec = 0; mepc = 0; ex_pc = 0; imm = 0; rs1_data = 0;
   endtask

   // One cycle: check outputs mid-cycle, predict the next state, clock it in.
   task automatic step();
      logic [31:0] tgt_raw, exp_bt, tgt, n_held;
      logic [31:0] n_pc [2];
      logic [31:0] inc [2];
      bit          n_pend;
      redir_src_e  n_src, w_src;
      inc[0] = 4;
      inc[1] = 2;
      @(negedge clk);
      tgt_raw = (jalr ? rs1_data : ex_pc) + imm;
      exp_bt  = jalr ? (tgt_raw & ~32'h1) : tgt_raw;

      chk("pc4", pc4, m_pc[0]);
      chk("pc2", pc2, m_pc[1]);
      chk("pending4", {31'b0, pend4}, {31'b0, m_pend});
      chk("pending2", {31'b0, pend2}, {31'b0, m_pend});
      chk("dbg_state", {31'b0, dbg4.state == HOLD}, {31'b0, m_pend});
      if (m_pend) chk("held_src", {30'b0, dbg4.src}, {30'b0, m_src});
      chk("br_target4", bt4, exp_bt);
      chk("br_target2", bt2, exp_bt);
      chk("misaligned4", {31'b0, mis4}, {31'b0, exp_bt[1]});
      chk("misaligned2", {31'b0, mis2}, 32'b0);
      chk("pc_plus4", pp4, m_pc[0] + 32'd4);
      chk("pc_plus2", pp2, m_pc[1] + 32'd2);

      n_held = m_held;
      n_src  = m_src;
      n_pend = m_pend;
      if (trap_take)     begin w_src = TRAP;   tgt = trap_vec; end
      else if (mret)     begin w_src = MRET;   tgt = mepc;     end
      else if (br_flush) begin w_src = BRANCH; tgt = exp_bt;   end
      else               begin w_src = NONE;   tgt = 0;        end
      for (int k = 0; k < 2; k++) begin
         if (m_pend) begin
            if (fetch_wait) n_pc[k] = m_pc[k];
            else            n_pc[k] = trap_take ? trap_vec : m_held;
         end else if (w_src != NONE) begin
            n_pc[k] = tgt;
         end else if (fetch_wait || mem_wait || wfi) begin
            n_pc[k] = m_pc[k];
         end else begin
            n_pc[k] = m_pc[k] + inc[k];
         end
      end
      if (m_pend) begin
         if (trap_take) begin n_held = trap_vec; n_src = TRAP; end
         n_pend = fetch_wait;
      end else if (w_src != NONE && fetch_wait) begin
         n_pend = 1; n_held = tgt; n_src = w_src;
      end

      if (!rst) begin
         chk("next_pc4", npc4, n_pc[0]);
         chk("next_pc2", npc2, n_pc[1]);
      end else begin
         n_pc[0] = RST_PC; n_pc[1] = RST_PC; n_pend = 0; n_held = 0; n_src = NONE;
      end

      @(posedge clk);
      #1;
      m_pc[0] = n_pc[0];
      m_pc[1] = n_pc[1];
      m_pend  = n_pend;
      m_held  = n_held;
      m_src   = n_src;
   endtask

   initial begin
      clear_inputs();
      rst = 1;
      repeat (2) @(posedge clk);
      #1;
      m_pc[0] = RST_PC; m_pc[1] = RST_PC; m_pend = 0; m_held = 0; m_src = NONE;
      rst = 0;

      // Free-running increment out of reset: 0x100, 0x104, 0x108.
      step(); step(); step();

      // Unstalled branch: 0x200 + 0x40.
      br_flush = 1; ex_pc = 32'h200; imm = 32'h40;
      step();
      clear_inputs();
      step();

      // Branch with fetch stalled for three cycles, then replay.
      br_flush = 1; ex_pc = 32'h200; imm = 32'h40; fetch_wait = 1;
      step();
      br_flush = 0; mret = 1; mepc = 32'h9000;
      step();
      mret = 0;
      step(); step();
      fetch_wait = 0;
      step(); step();

      // Trap while holding 0x240 replaces the held target.
      br_flush = 1; ex_pc = 32'h200; imm = 32'h40; fetch_wait = 1;
      step();
      clear_inputs(); fetch_wait = 1;
      step();
      trap_take = 1; trap_vec = 32'h8000;
      step();
      trap_take = 0;
      step();
      fetch_wait = 0;
      step(); step();

      // JALR target with bit 0 cleared and bit 1 misaligned.
      br_flush = 1; jalr = 1; rs1_data = 32'h1003; imm = 0; ex_pc = 32'h40;
      step();
      clear_inputs();
      step();

      // All three redirects together: the trap wins.
      trap_take = 1; trap_vec = 32'h3000; mret = 1; mepc = 32'h4000;
      br_flush = 1; ex_pc = 32'h500; imm = 32'h10;
      step();
      clear_inputs();
      step();

      // Reset while holding discards the pending target.
      br_flush = 1; ex_pc = 32'h600; imm = 32'h8; fetch_wait = 1;
      step();
      br_flush = 0;
      step();
      rst = 1;
      step();
      rst = 0; fetch_wait = 0;
      step(); step();

      // Increment wraps past the top of the address space.
      trap_take = 1; trap_vec = 32'hFFFF_FFFC;
      step();
      trap_take = 0;
      step(); step();

      for (int i = 0; i < 400; i++) begin
         rst        = ($urandom_range(0, 59) == 0);
         fetch_wait = ($urandom_range(0, 9) < 3);
         mem_wait   = ($urandom_range(0, 9) == 0);
         wfi        = ($urandom_range(0, 19) == 0);
         trap_take  = ($urandom_range(0, 11) == 0);
         mret       = ($urandom_range(0, 11) == 0);
         br_flush   = ($urandom_range(0, 4) == 0);
         jalr       = $urandom_range(0, 1);
         trap_vec   = $urandom & ~32'h3;
         mepc       = $urandom;
         ex_pc      = $urandom;
         imm        = $urandom;
         rs1_data   = $urandom;
         step();
      end
      clear_inputs();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
